// File: rtl/riscv_pkg.sv
// Shared RV32I datapath constants and small helpers for the pipeline stages.
package riscv_pkg;

    localparam int XLEN           = 32;
    localparam int REG_IDX_W      = 5;
    localparam int DMEM_DEPTH_DEF = 1024;

    // A word access is misaligned when either byte-offset bit is set.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory: synchronous write, asynchronous read.
// Contents survive reset; only the write strobe is gated by rst.
module data_memory #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            WE,
    input  logic [AW-1:0]   A,
    input  logic [XLEN-1:0] WD,
    output logic [XLEN-1:0] RD
);

    logic [XLEN-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst && WE) begin
            mem_q[A] <= WD;
        end
    end

    // Read is combinational, so a same-edge store is seen only next cycle.
    assign RD = mem_q[A];

endmodule

// File: rtl/memory_cycle_stage.sv
// MEM stage of the RV32I pipeline: data memory access plus the MEM/WB register.
// Optional build macro MEM_MISALIGN_CHECK_EN adds MisalignW and blocks misaligned stores.
module memory_cycle_stage #(
    parameter int XLEN       = riscv_pkg::XLEN,
    parameter int DMEM_DEPTH = riscv_pkg::DMEM_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           RegWriteM,
    input  logic                           MemWriteM,
    input  logic                           ResultSrcM,
    input  logic [riscv_pkg::REG_IDX_W-1:0] RD_M,
    input  logic [XLEN-1:0]                PCPlus4M,
    input  logic [XLEN-1:0]                WriteDataM,
    input  logic [XLEN-1:0]                ALU_ResultM,
    output logic                           RegWriteW,
    output logic                           ResultSrcW,
    output logic [riscv_pkg::REG_IDX_W-1:0] RD_W,
    output logic [XLEN-1:0]                PCPlus4W,
    output logic [XLEN-1:0]                ALU_ResultW,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic                           MisalignW,
`endif
    output logic [XLEN-1:0]                ReadDataW
);

    import riscv_pkg::*;

    localparam int DMEM_AW = $clog2(DMEM_DEPTH);

    logic [DMEM_AW-1:0]   word_idx;
    logic                 mem_we;
    logic [XLEN-1:0]      read_data;

    logic                 reg_write_d,   reg_write_q;
    logic                 result_src_d,  result_src_q;
    logic [REG_IDX_W-1:0] rd_d,          rd_q;
    logic [XLEN-1:0]      pc_plus4_d,    pc_plus4_q;
    logic [XLEN-1:0]      alu_result_d,  alu_result_q;
    logic [XLEN-1:0]      read_data_d,   read_data_q;

    // Byte offset and bits above the memory size are dropped: addresses wrap.
    assign word_idx = ALU_ResultM[DMEM_AW+1:2];

`ifdef MEM_MISALIGN_CHECK_EN
    logic misalign_d, misalign_q;

    assign mem_we     = MemWriteM & ~is_misaligned(ALU_ResultM[1:0]);
    assign misalign_d = (MemWriteM | ResultSrcM) & is_misaligned(ALU_ResultM[1:0]);
    assign MisalignW  = misalign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    assign mem_we = MemWriteM;
`endif

    data_memory #(
        .XLEN  (XLEN),
        .DEPTH (DMEM_DEPTH)
    ) u_dmem (
        .clk (clk),
        .rst (rst),
        .WE  (mem_we),
        .A   (word_idx),
        .WD  (WriteDataM),
        .RD  (read_data)
    );

    assign reg_write_d  = RegWriteM;
    assign result_src_d = ResultSrcM;
    assign rd_d         = RD_M;
    assign pc_plus4_d   = PCPlus4M;
    assign alu_result_d = ALU_ResultM;
    assign read_data_d  = read_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
        end
    end

    assign RegWriteW   = reg_write_q;
    assign ResultSrcW  = result_src_q;
    assign RD_W        = rd_q;
    assign PCPlus4W    = pc_plus4_q;
    assign ALU_ResultW = alu_result_q;
    assign ReadDataW   = read_data_q;

endmodule

// File: tb/tb_memory_cycle_stage.sv
// Bench for memory_cycle_stage: directed cases plus random traffic against a word-array model.
module tb_memory_cycle_stage;

    localparam int XLEN  = 32;
    localparam int DEPTH = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]        RD_M;
    logic [XLEN-1:0]   PCPlus4M, WriteDataM, ALU_ResultM;
    logic              RegWriteW, ResultSrcW;
    logic [4:0]        RD_W;
    logic [XLEN-1:0]   PCPlus4W, ALU_ResultW, ReadDataW;
`ifdef MEM_MISALIGN_CHECK_EN
    logic              MisalignW;
`endif

    always #5 clk = ~clk;

    memory_cycle_stage #(.XLEN(XLEN), .DMEM_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .PCPlus4M    (PCPlus4M),
        .WriteDataM  (WriteDataM),
        .ALU_ResultM (ALU_ResultM),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RD_W        (RD_W),
        .PCPlus4W    (PCPlus4W),
        .ALU_ResultW (ALU_ResultW),
`ifdef MEM_MISALIGN_CHECK_EN
        .MisalignW   (MisalignW),
`endif
        .ReadDataW   (ReadDataW)
    );

    // Reference model: plain word array indexed by (byte address / 4) mod DEPTH.
    logic [XLEN-1:0] model_mem [DEPTH];
    bit              known     [DEPTH];

    logic            e_rw, e_rs, e_mis, e_known;
    logic [4:0]      e_rd;
    logic [XLEN-1:0] e_pc, e_alu, e_data;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic rs, input logic rw, input logic [4:0] rd,
                         input logic [XLEN-1:0] pc, input logic [XLEN-1:0] wd, input logic [XLEN-1:0] addr);
        MemWriteM   = we;
        ResultSrcM  = rs;
        RegWriteM   = rw;
        RD_M        = rd;
        PCPlus4M    = pc;
        WriteDataM  = wd;
        ALU_ResultM = addr;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rw"},  {31'd0, RegWriteW},  {31'd0, e_rw});
        check({tag, ".rs"},  {31'd0, ResultSrcW}, {31'd0, e_rs});
        check({tag, ".rd"},  {27'd0, RD_W},       {27'd0, e_rd});
        check({tag, ".pc"},  PCPlus4W,    e_pc);
        check({tag, ".alu"}, ALU_ResultW, e_alu);
        if (e_known) check({tag, ".data"}, ReadDataW, e_data);
`ifdef MEM_MISALIGN_CHECK_EN
        check({tag, ".mis"}, {31'd0, MisalignW}, {31'd0, e_mis});
`endif
    endtask

    task automatic clear_expect();
        e_rw = 0; e_rs = 0; e_rd = 0; e_pc = 0; e_alu = 0;
        e_data = 0; e_known = 1; e_mis = 0;
    endtask

    // One clock: predict from the currently driven inputs, clock, then compare.
    task automatic step(input string tag);
        int   idx;
        logic do_store;
        logic mis;
        idx      = int'(ALU_ResultM >> 2) % DEPTH;
        mis      = (ALU_ResultM % 4) != 0;
        do_store = MemWriteM;
`ifdef MEM_MISALIGN_CHECK_EN
        if (mis) do_store = 1'b0;
`endif
        @(posedge clk);
        if (rst) begin
            e_rw    = RegWriteM;
            e_rs    = ResultSrcM;
            e_rd    = RD_M;
            e_pc    = PCPlus4M;
            e_alu   = ALU_ResultM;
            e_data  = model_mem[idx];
            e_known = known[idx];
            e_mis   = (MemWriteM || ResultSrcM) && mis;
            if (do_store) begin
                model_mem[idx] = WriteDataM;
                known[idx]     = 1'b1;
            end
        end else begin
            clear_expect();
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [XLEN-1:0] addr;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1 rst = 1'b0;

        // Reset held for 100 ns with toggling inputs, stores included.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
            step("rst_hold");
        end

        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 1, 4, 32'h10, 32'h0, 32'hABCDEF00);
        step("pass");
        check("pass.alu_const", ALU_ResultW, 32'hABCDEF00);

        // Zero every word so later reads have defined expectations.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 0, 0, 0, 0, 32'(i * 4));
            step("sweep");
        end

        drive(1, 0, 0, 2, 32'h8, 32'h12345678, 32'h4);
        step("st4");
        drive(0, 1, 1, 3, 32'hC, 32'h0, 32'h4);
        step("ld4");
        check("ld4.const", ReadDataW, 32'h12345678);

        drive(1, 0, 0, 0, 32'h10, 32'h87654321, 32'h8);
        step("st8");
        drive(0, 1, 1, 5, 32'h14, 32'h0, 32'h8);
        step("ld8");
        check("ld8.const", ReadDataW, 32'h87654321);
        drive(0, 1, 1, 6, 32'h18, 32'h0, 32'h4);
        step("ld4b");
        check("ld4b.const", ReadDataW, 32'h12345678);

        // Asynchronous reset mid-cycle with a store pending at 0xC.
        #2 rst = 1'b0;
        #1;
        clear_expect();
        check_outputs("async_rst");
        drive(1, 0, 1, 7, 32'h1C, 32'hAABBCCDD, 32'hC);
        step("rst_st");
        step("rst_st");
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1, 1, 8, 32'h20, 32'h0, 32'hC);
        step("ldC");
        check("ldC.const", ReadDataW, 32'h0);

        // Read-before-write on one index, then a wrapped address.
        drive(1, 1, 0, 0, 32'h24, 32'h11, 32'h4);
        step("rbw1");
        drive(1, 1, 0, 0, 32'h28, 32'h22, 32'h4);
        step("rbw2");
        check("rbw2.const", ReadDataW, 32'h11);
        drive(0, 1, 1, 9, 32'h2C, 32'h0, 32'(4 + 4 * DEPTH));
        step("wrap");
        check("wrap.const", ReadDataW, 32'h22);

        // Random traffic over a small hot set with offsets and wrap bits.
        for (int i = 0; i < 400; i++) begin
            addr = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) addr = addr | (32'($urandom) << 12);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom), $urandom, $urandom, addr);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
